dut_pipeline: RTL and testbench



---
 rtl/dut_pkg.sv | 21 ++
 rtl/dut_pipeline_compute.sv | 60 ++++++
 rtl/dut_pipeline.sv | 114 +++++++++++
 tb/tb_dut_pipeline.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dut_pkg.sv
// Shared types and limits for the picoview probe-path pipeline.
// Holds the operation encoding and the legal latency range.
package dut_pkg;

    typedef enum logic [1:0] {
        DUT_ADD = 2'd0,
        DUT_SUB = 2'd1,
        DUT_XOR = 2'd2,
        DUT_ACC = 2'd3
    } dut_mode_t;

    localparam int MIN_LATENCY = 1;
    localparam int MAX_LATENCY = 8;

    // Width must split into two equal halves of at least two bits each.
    function automatic bit params_ok(int data_width, int latency);
        return (data_width >= 4) && ((data_width % 2) == 0) &&
               (latency >= MIN_LATENCY) && (latency <= MAX_LATENCY);
    endfunction

endpackage

// File: rtl/dut_pipeline_compute.sv
// Combinational stage-1 datapath: the selected operation on the two halves.
// The accumulator path applies clear first, then adds both halves.
module dut_compute
    import dut_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int H          = DATA_WIDTH / 2
) (
    input  logic [H-1:0]          upper_i,
    input  logic [H-1:0]          lower_i,
    input  logic [1:0]            mode_i,
    input  logic [DATA_WIDTH-1:0] acc_i,
    input  logic                  clear_acc_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  carry_o,
    output logic [DATA_WIDTH-1:0] acc_next_o
);

    logic [DATA_WIDTH-1:0] u_ext;
    logic [DATA_WIDTH-1:0] l_ext;
    logic [DATA_WIDTH-1:0] half_sum;
    logic [DATA_WIDTH-1:0] acc_base;
    logic [DATA_WIDTH:0]   acc_sum;

    always_comb begin
        u_ext      = {{H{1'b0}}, upper_i};
        l_ext      = {{H{1'b0}}, lower_i};
        half_sum   = u_ext + l_ext;
        acc_base   = clear_acc_i ? '0 : acc_i;
        // One extra bit catches the wrap of the running sum.
        acc_sum    = {1'b0, acc_base} + {1'b0, half_sum};
        acc_next_o = acc_sum[DATA_WIDTH-1:0];

        result_o = '0;
        carry_o  = 1'b0;
        case (dut_mode_t'(mode_i))
            DUT_ADD: begin
                result_o = half_sum;
                carry_o  = half_sum[H];
            end
            DUT_SUB: begin
                result_o = u_ext - l_ext;
                carry_o  = (upper_i < lower_i);
            end
            DUT_XOR: begin
                result_o = u_ext ^ l_ext;
                carry_o  = 1'b0;
            end
            DUT_ACC: begin
                result_o = acc_sum[DATA_WIDTH-1:0];
                carry_o  = acc_sum[DATA_WIDTH];
            end
            default: begin
                result_o = '0;
                carry_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dut_pipeline.sv
// Pipelined probe-path DUT: compute in stage 1, then LATENCY-1 delay stages.
// Handshake: in_ready = advance = !out_valid | out_ready; the pipe shifts as one.
module dut_pipeline
    import dut_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int LATENCY      = 2,
    parameter int SELECT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   dut_input,
    input  logic [1:0]              dut_mode,
    input  logic [SELECT_WIDTH-1:0] dut_signal_select,
    input  logic                    clear_acc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   dut_result,
    output logic                    dut_output,
    output logic                    dut_carry
);

    localparam int H = DATA_WIDTH / 2;

    if (!params_ok(DATA_WIDTH, LATENCY)) begin : g_param_check
        $error("dut_pipeline: DATA_WIDTH must be even and >= 4, LATENCY in 1..8");
    end

    logic                  advance;
    logic                  accept;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0] acc_d;
    logic [DATA_WIDTH-1:0] comp_result;
    logic                  comp_carry;
    logic [DATA_WIDTH-1:0] comp_acc_next;

    logic                    valid_q  [LATENCY];
    logic [DATA_WIDTH-1:0]   result_q [LATENCY];
    logic [SELECT_WIDTH-1:0] sel_q    [LATENCY];
    logic                    carry_q  [LATENCY];

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance;

    dut_compute #(
        .DATA_WIDTH (DATA_WIDTH),
        .H          (H)
    ) u_compute (
        .upper_i     (dut_input[DATA_WIDTH-1:H]),
        .lower_i     (dut_input[H-1:0]),
        .mode_i      (dut_mode),
        .acc_i       (acc_q),
        .clear_acc_i (clear_acc),
        .result_o    (comp_result),
        .carry_o     (comp_carry),
        .acc_next_o  (comp_acc_next)
    );

    // Clear applies on its own edge even when nothing is accepted.
    always_comb begin
        acc_d = acc_q;
        if (accept && (dut_mode == DUT_ACC)) begin
            acc_d = comp_acc_next;
        end else if (clear_acc) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                valid_q[i]  <= 1'b0;
                result_q[i] <= '0;
                sel_q[i]    <= '0;
                carry_q[i]  <= 1'b0;
            end
        end else if (advance) begin
            valid_q[0]  <= accept;
            result_q[0] <= comp_result;
            sel_q[0]    <= dut_signal_select;
            carry_q[0]  <= comp_carry;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i]  <= valid_q[i-1];
                result_q[i] <= result_q[i-1];
                sel_q[i]    <= sel_q[i-1];
                carry_q[i]  <= carry_q[i-1];
            end
        end
    end

    assign out_valid  = valid_q[LATENCY-1];
    assign dut_result = result_q[LATENCY-1];
    assign dut_carry  = carry_q[LATENCY-1];

    // Selects past the top bit (non power-of-two widths) read as 0.
    always_comb begin
        dut_output = 1'b0;
        if (32'(sel_q[LATENCY-1]) < DATA_WIDTH) begin
            dut_output = result_q[LATENCY-1][sel_q[LATENCY-1]];
        end
    end

endmodule

// File: tb/tb_dut_pipeline.sv
// Scoreboard bench for dut_pipeline (DATA_WIDTH=32, LATENCY=2).
// Expected results are queued at accept and popped when a result beat is taken.
module tb_dut_pipeline;
  localparam int DW = 32;
  localparam int SW = 5;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dut_input = '0;
  logic [1:0]    dut_mode = 2'd0;
  logic [SW-1:0] dut_signal_select = '0;
  logic          clear_acc = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] dut_result;
  logic          dut_output;
  logic          dut_carry;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW+1:0] exp_q[$];
  logic [DW-1:0] model_acc = '0;
  bit            rand_rdy = 1'b0;
  bit            stall_prev = 1'b0;
  logic [DW+1:0] held_val = '0;

  dut_pipeline #(.DATA_WIDTH(DW), .LATENCY(LAT), .SELECT_WIDTH(SW)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dut_input(dut_input), .dut_mode(dut_mode),
    .dut_signal_select(dut_signal_select), .clear_acc(clear_acc),
    .out_valid(out_valid), .out_ready(out_ready), .dut_result(dut_result),
    .dut_output(dut_output), .dut_carry(dut_carry)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: returns {result, probe bit, carry} and advances model_acc.
  function automatic logic [DW+1:0] model(input logic [DW-1:0] w, input logic [1:0] m,
                                          input logic [SW-1:0] sel, input logic clr);
    logic [DW-1:0] u, l, r, base;
    logic [DW:0]   s;
    logic          c, ob;
    u = {16'h0, w[31:16]};
    l = {16'h0, w[15:0]};
    base = clr ? '0 : model_acc;
    if (clr) model_acc = '0;
    case (m)
      2'd0: begin r = u + l; c = r[16]; end
      2'd1: begin r = u - l; c = (u < l); end
      2'd2: begin r = u ^ l; c = 1'b0; end
      default: begin
        s = {1'b0, base} + {1'b0, u} + {1'b0, l};
        r = s[DW-1:0];
        c = s[DW];
        model_acc = r;
      end
    endcase
    ob = (int'(sel) < DW) ? r[sel] : 1'b0;
    return {r, ob, c};
  endfunction

  // driver: present a beat after a rising edge, wait for acceptance (bounded)
  task automatic send(input logic [DW-1:0] w, input logic [1:0] m,
                      input logic [SW-1:0] sel, input logic clr);
    int guard;
    in_valid = 1'b1;
    dut_input = w;
    dut_mode = m;
    dut_signal_select = sel;
    clear_acc = clr;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    else exp_q.push_back(model(w, m, sel, clr));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear_acc = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // scoreboard / monitor on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev && out_valid)
        check("held_stable", 64'({dut_result, dut_output, dut_carry}), 64'(held_val));
      if (out_valid && !out_ready)
        check("in_ready_stall", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_beat", 64'd1, 64'd0);
        else check("result", 64'({dut_result, dut_output, dut_carry}), 64'(exp_q.pop_front()));
      end
      stall_prev = out_valid && !out_ready;
      held_val = {dut_result, dut_output, dut_carry};
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(dut_result), 64'd0);
    check("rst_carry", 64'({dut_output, dut_carry}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // 1: ADD with latency probe
    send(32'hFFFF_0001, 2'd0, 5'd16, 1'b0);
    @(negedge clk);
    check("lat_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lat_exact", 64'(out_valid), 64'd1);
    drain(20);

    // 2: SUB and XOR
    send(32'h0001_0003, 2'd1, 5'd0, 1'b0);
    send(32'h00FF_0F0F, 2'd2, 5'd4, 1'b0);
    drain(20);

    // 3: accumulate, clear with beat, ADD leaves acc alone
    repeat (3) send(32'h0002_0003, 2'd3, 5'd0, 1'b0);
    send(32'h0002_0003, 2'd3, 5'd0, 1'b1);
    send(32'h0002_0003, 2'd0, 5'd1, 1'b0);
    send(32'h0002_0003, 2'd3, 5'd1, 1'b0);
    drain(20);

    // 4: stream through a consumer stall
    fork
      begin
        send(32'h0010_0001, 2'd0, 5'd0, 1'b0);
        send(32'h0020_0002, 2'd0, 5'd1, 1'b0);
        send(32'h0030_0003, 2'd0, 5'd4, 1'b0);
        send(32'h8000_8000, 2'd0, 5'd16, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain(40);

    // 5: mode/select changes after acceptance must not reach in-flight beats
    send(32'h0005_0003, 2'd1, 5'd1, 1'b0);
    send(32'h0F00_00F0, 2'd2, 5'd8, 1'b0);
    dut_mode = 2'd0;
    dut_signal_select = 5'd31;
    drain(20);

    // 6: reset with a beat in flight
    send(32'h1234_1234, 2'd3, 5'd0, 1'b0);
    send(32'h1234_1234, 2'd3, 5'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    exp_q.delete();
    model_acc = '0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(32'h0000_0001, 2'd3, 5'd0, 1'b0);
    drain(20);

    // random traffic with random back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send($urandom, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 7) == 0));
    end
    drain(400);
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
